// File: rtl/iob_uart_txfifo.sv
// Transmit FIFO sitting in front of uart_core: buffers TXDATA writes and
// hands them to the core one byte at a time whenever it reports tx_ready.
module iob_uart_txfifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int GUARD_CYC = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              soft_rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              tx_en_i,
    input  logic              tx_ready_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              data_write_en_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic [1:0]        state_o
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      GUARD_INIT = 4'(GUARD_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [3:0]        guard_q;
    state_t            state_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              dwe_q;
    logic              overflow_q;

    logic full, empty, pop, push, drop;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign pop   = (state_q == ST_IDLE) & tx_en_i & tx_ready_i & ~empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign push  = wr_en_i & (~full | pop);
    assign drop  = wr_en_i & full & ~pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (cke_i && !soft_rst_i && push) mem_q[wptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            guard_q    <= '0;
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            dwe_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else if (cke_i) begin
            if (soft_rst_i) begin
                wptr_q     <= '0;
                rptr_q     <= '0;
                level_q    <= '0;
                guard_q    <= '0;
                state_q    <= ST_IDLE;
                dwe_q      <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                level_q <= level_d;
                if (drop) overflow_q <= 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        dwe_q <= pop;
                        if (pop) begin
                            tx_data_q <= mem_q[rptr_q];
                            state_q   <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        dwe_q   <= 1'b0;
                        guard_q <= GUARD_INIT;
                        state_q <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        // The core needs a few cycles to drop tx_ready after a write.
                        dwe_q   <= 1'b0;
                        guard_q <= guard_q - 1'b1;
                        if (guard_q <= 4'd1) state_q <= ST_IDLE;
                    end
                    default: begin
                        dwe_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_data_o       = tx_data_q;
    assign data_write_en_o = dwe_q;
    assign full_o          = full;
    assign empty_o         = empty;
    assign level_o         = level_q;
    assign overflow_o      = overflow_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_iob_uart_txfifo.sv
// Bench for iob_uart_txfifo: pushed bytes go to an expected queue and every
// write pulse towards uart_core is popped and compared in order.
module tb_iob_uart_txfifo;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       cke = 1'b1;
    logic       soft_rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_en = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       dwe;
    logic       full, empty, overflow;
    logic [4:0] level;
    logic [1:0] state;

    iob_uart_txfifo #(.DATA_W(8), .ADDR_W(4), .GUARD_CYC(2)) dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .soft_rst_i(soft_rst),
        .wr_en_i(wr_en), .wr_data_i(wr_data), .tx_en_i(tx_en), .tx_ready_i(tx_ready),
        .tx_data_o(tx_data), .data_write_en_o(dwe), .full_o(full), .empty_o(empty),
        .level_o(level), .overflow_o(overflow), .state_o(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         pulse_cnt = 0;
    int         last_pulse_cyc = -1;
    bit         spacing_on = 1'b0;
    logic [7:0] last_data = '0;
    logic [7:0] mon_exp;

    // Scoreboard: each write pulse must carry the oldest accepted byte.
    always @(negedge clk) begin
        if (arst && dwe === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got data %h, no byte expected", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_data !== mon_exp) begin
                    errors++;
                    $display("FAIL pulse_data: got %h expected %h", tx_data, mon_exp);
                end
            end
            if (spacing_on && last_pulse_cyc >= 0) begin
                checks++;
                if (cyc - last_pulse_cyc != 4) begin
                    errors++;
                    $display("FAIL issue_spacing: got %0d expected 4", cyc - last_pulse_cyc);
                end
            end
            last_pulse_cyc = cyc;
            last_data      = tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_pulse(input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (pulse_cnt > base) ok = 1'b1;
        end
        if (!ok) begin
            errors++;
            $display("FAIL pulse_timeout: got %0d pulses expected more than %0d", pulse_cnt, base);
        end
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        repeat (6) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (dwe !== 1'b0)      begin errors++; $display("FAIL rst_dwe: got %b expected 0", dwe); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        if (full !== 1'b0)     begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
        if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        if (level !== 5'd0)    begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        if (state !== 2'd0)    begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
        arst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base, p;
        bit ok;
        tx_en = 1'b1; tx_ready = 1'b1;
        base = pulse_cnt;
        p = cyc;
        push(8'h55, 1'b1);
        wait_pulse(base, 10, ok);
        checks++;
        if (last_pulse_cyc !== p + 2) begin
            errors++; $display("FAIL single_latency: got cycle %0d expected %0d", last_pulse_cyc, p + 2);
        end
        repeat (10) tick();
        checks += 3;
        if (pulse_cnt !== base + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", pulse_cnt - base, 1); end
        if (level !== 5'd0)  begin errors++; $display("FAIL single_level: got %0d expected 0", level); end
        if (empty !== 1'b1)  begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
    endtask

    task automatic test_fill_overflow();
        int base;
        tx_en = 1'b0; tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
        checks += 2;
        if (full !== 1'b1)    begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        if (level !== 5'd16)  begin errors++; $display("FAIL fill_level: got %0d expected 16", level); end
        push(8'hAA, 1'b0);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        if (level !== 5'd16)   begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
        base = pulse_cnt;
        last_pulse_cyc = -1;
        spacing_on = 1'b1;
        tx_en = 1'b1;
        wait_drain(200);
        spacing_on = 1'b0;
        checks += 2;
        if (pulse_cnt - base !== 16) begin errors++; $display("FAIL drain_count: got %0d expected 16", pulse_cnt - base); end
        if (empty !== 1'b1)          begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_pop();
        int base;
        tx_en = 1'b0; tx_ready = 1'b1;
        soft_rst = 1'b1; tick(); soft_rst = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL srst_ovf_clear: got %b expected 0", overflow); end
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)), 1'b1);
        base = pulse_cnt;
        tx_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
        tick();
        wr_en = 1'b0;
        checks += 3;
        if (level !== 5'd16)   begin errors++; $display("FAIL fullpop_level: got %0d expected 16", level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b expected 0", overflow); end
        if (full !== 1'b1)     begin errors++; $display("FAIL fullpop_full: got %b expected 1", full); end
        wait_drain(200);
        checks += 2;
        if (pulse_cnt - base !== 17) begin errors++; $display("FAIL fullpop_count: got %0d expected 17", pulse_cnt - base); end
        if (last_data !== 8'h77)     begin errors++; $display("FAIL fullpop_last: got %h expected 77", last_data); end
    endtask

    task automatic test_ready_gap();
        int base, pc, r;
        bit ok;
        tx_en = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)), 1'b1);
        base = pulse_cnt;
        r = 0;
        tx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_pulse(base + i, 30, ok);
            if (i > 0) begin
                checks++;
                if (last_pulse_cyc !== r + 1) begin
                    errors++; $display("FAIL gap_resume: got cycle %0d expected %0d", last_pulse_cyc, r + 1);
                end
            end
            tx_ready = 1'b0;
            pc = pulse_cnt;
            repeat (10) tick();
            checks++;
            if (pulse_cnt !== pc) begin errors++; $display("FAIL gap_quiet: got %0d pulses expected 0", pulse_cnt - pc); end
            tx_ready = 1'b1;
            r = cyc;
        end
        repeat (20) tick();
        checks += 2;
        if (pulse_cnt - base !== 3) begin errors++; $display("FAIL gap_count: got %0d expected 3", pulse_cnt - base); end
        if (exp_q.size() !== 0)     begin errors++; $display("FAIL gap_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_soft_rst();
        int base;
        bit ok;
        logic [7:0] held;
        tx_en = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)), 1'b1);
        base = pulse_cnt;
        tx_en = 1'b1;
        wait_pulse(base, 10, ok);
        held = last_data;
        soft_rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        soft_rst = 1'b0; wr_en = 1'b0;
        exp_q.delete();
        checks += 6;
        if (level !== 5'd0)    begin errors++; $display("FAIL srst_level: got %0d expected 0", level); end
        if (empty !== 1'b1)    begin errors++; $display("FAIL srst_empty: got %b expected 1", empty); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL srst_overflow: got %b expected 0", overflow); end
        if (state !== 2'd0)    begin errors++; $display("FAIL srst_state: got %0d expected 0", state); end
        if (dwe !== 1'b0)      begin errors++; $display("FAIL srst_dwe: got %b expected 0", dwe); end
        if (tx_data !== held)  begin errors++; $display("FAIL srst_tx_hold: got %h expected %h", tx_data, held); end
        repeat (20) tick();
        checks += 2;
        if (pulse_cnt !== base + 1) begin errors++; $display("FAIL srst_no_pulse: got %0d expected 1", pulse_cnt - base); end
        if (level !== 5'd0)         begin errors++; $display("FAIL srst_discard: got %0d expected 0", level); end
    endtask

    task automatic test_cke_freeze();
        int base, t;
        bit ok;
        logic [4:0] lvl;
        logic [1:0] st;
        logic [7:0] td;
        tx_en = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)), 1'b1);
        base = pulse_cnt;
        tx_en = 1'b1;
        wait_pulse(base, 10, ok);
        t = last_pulse_cyc;
        lvl = level; st = state; td = tx_data;
        cke = 1'b0; wr_en = 1'b1;
        repeat (8) begin
            wr_data = 8'($urandom_range(0, 255));
            tick();
        end
        checks += 4;
        if (level !== lvl)          begin errors++; $display("FAIL cke_level: got %0d expected %0d", level, lvl); end
        if (state !== st)           begin errors++; $display("FAIL cke_state: got %0d expected %0d", state, st); end
        if (tx_data !== td)         begin errors++; $display("FAIL cke_tx_data: got %h expected %h", tx_data, td); end
        if (pulse_cnt !== base + 1) begin errors++; $display("FAIL cke_pulses: got %0d expected 1", pulse_cnt - base); end
        cke = 1'b1; wr_en = 1'b0;
        wait_pulse(base + 1, 20, ok);
        checks++;
        if (last_pulse_cyc !== t + 12) begin
            errors++; $display("FAIL cke_resume: got cycle %0d expected %0d", last_pulse_cyc, t + 12);
        end
        wait_drain(100);
        checks++;
        if (pulse_cnt - base !== 4) begin errors++; $display("FAIL cke_count: got %0d expected 4", pulse_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_pop();
        test_ready_gap();
        test_soft_rst();
        test_cke_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
